// File: rtl/ram_portb_scheduler.sv
// ram_portb_scheduler
// Owns port B of the dual-port data RAM. After reset or on clear_req it
// zero-fills the whole RAM while holding the CPU in reset; otherwise it
// shares port B between two requesters with round-robin arbitration.
module ram_portb_scheduler #(
  parameter int unsigned DATA_WIDTH         = 16,
  parameter int unsigned RAM_REGISTER_COUNT = 1024,
  parameter int unsigned ADDR_WIDTH         = $clog2(RAM_REGISTER_COUNT)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    clear_req,
  output logic                    cpu_hold,
  output logic                    busy_clear,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [ADDR_WIDTH-1:0]   ram_address_b,
  output logic [DATA_WIDTH-1:0]   ram_data_b,
  output logic                    ram_wren_b,
  input  logic [DATA_WIDTH-1:0]   ram_q_b
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } state_t;

  // Last sweep address; compared directly so the pointer never wraps.
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(RAM_REGISTER_COUNT - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_ptr;
  logic [ADDR_WIDTH-1:0]   w_ptr_nxt;
  logic                    r_last_grant;
  logic                    w_last_grant_nxt;
  logic [1:0]              r_rsp_valid;
  logic [1:0]              w_rsp_valid_nxt;
  logic                    w_gnt;
  logic [ADDR_WIDTH-1:0]   w_gnt_addr;
  logic [DATA_WIDTH-1:0]   w_gnt_wdata;
  logic                    w_gnt_we;

  // Round-robin pick: a lone requester wins, a tie goes to the one that did not win last.
  assign w_gnt       = (req_valid == 2'b10) || ((req_valid == 2'b11) && !r_last_grant);
  assign w_gnt_addr  = w_gnt ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign w_gnt_wdata = w_gnt ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  assign w_gnt_we    = w_gnt ? req_we[1] : req_we[0];

  // Read data is the RAM output passed straight through, qualified by rsp_valid.
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = ram_q_b;

  // State, sweep pointer, arbitration history and pending read responses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= ST_CLEAR;
      r_ptr        <= '0;
      r_last_grant <= 1'b1;
      r_rsp_valid  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
    end
  end

  // Next-state and port-B drive: sweep writes in CLEAR, granted transfer in ARB.
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_last_grant_nxt = r_last_grant;
    w_rsp_valid_nxt  = 2'b00;
    req_ready        = 2'b00;
    ram_address_b    = '0;
    ram_data_b       = '0;
    ram_wren_b       = 1'b0;
    cpu_hold         = 1'b0;
    busy_clear       = 1'b0;

    case (r_state)
      ST_CLEAR: begin
        cpu_hold      = 1'b1;
        busy_clear    = 1'b1;
        ram_wren_b    = 1'b1;
        ram_address_b = r_ptr;
        if (r_ptr == PTR_LAST) begin
          w_state_nxt = ST_ARB;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + ADDR_WIDTH'(1);
        end
      end

      ST_ARB: begin
        if (clear_req) begin
          w_state_nxt = ST_CLEAR;
          w_ptr_nxt   = '0;
        end else if (req_valid[w_gnt]) begin
          req_ready        = w_gnt ? 2'b10 : 2'b01;
          ram_address_b    = w_gnt_addr;
          ram_data_b       = w_gnt_wdata;
          ram_wren_b       = w_gnt_we;
          w_last_grant_nxt = w_gnt;
          if (!w_gnt_we) begin
            w_rsp_valid_nxt = w_gnt ? 2'b10 : 2'b01;
          end
        end
      end

      default: begin
        w_state_nxt = ST_CLEAR;
        w_ptr_nxt   = '0;
      end
    endcase
  end

endmodule
